// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered IRQ capture, boundary-time interrupt entry, EI/DI/RETI/HALT handling
module interrupt_controller #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [15:0] VECTOR_BASE  = 16'h0010,
  parameter int          VECTOR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch,
  input  logic               commit,
  input  logic               eix,
  input  logic               dix,
  input  logic               retix,
  input  logic               haltx,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               int_take,
  output logic [15:0]        int_vector,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               ie,
  output logic               in_service,
  output logic               halted,
  output logic               run
);
  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t state, state_nx;
  logic [NUM_IRQ-1:0] s1, s2, s3, pending, pending_nx, win, rise;
  logic [15:0] win_idx;
  logic any, take, ie_nx, in_service_nx, unused;
  assign unused = fetch;
  assign rise = s2 & ~s3;
  assign any = |pending;
  assign win = pending & (~pending + NUM_IRQ'(1));
  assign halted = state == S_HALT;
  assign run = ~halted;
  // lowest pending index wins
  always_comb begin
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pending[i]) win_idx = 16'(i);
  end
  // boundary / wake decision using the registered IE from before this edge
  always_comb begin
    take = 1'b0;
    ie_nx = ie;
    in_service_nx = in_service;
    state_nx = state;
    if (state == S_HALT) begin
      if (any) begin
        state_nx = S_RUN;
        take = ie & ~in_service;
      end
    end else if (commit) begin
      take = ie & ~dix & ~in_service & any & ~haltx;
      ie_nx = dix ? 1'b0 : eix ? 1'b1 : ie;
      if (retix) begin
        ie_nx = 1'b1;
        in_service_nx = 1'b0;
      end
      if (haltx && !any) state_nx = S_HALT;
    end
    if (take) begin
      ie_nx = 1'b0;
      in_service_nx = 1'b1;
    end
    pending_nx = (pending & ~(take ? win : '0)) | rise;
  end
  // state, synchronizers and registered entry outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pending <= '0;
      state <= S_RUN;
      ie <= 1'b0;
      in_service <= 1'b0;
      int_take <= 1'b0;
      int_ack <= '0;
      int_vector <= VECTOR_BASE;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
      pending <= pending_nx;
      state <= state_nx;
      ie <= ie_nx;
      in_service <= in_service_nx;
      int_take <= take;
      int_ack <= take ? win : '0;
      if (take) int_vector <= VECTOR_BASE + (win_idx << VECTOR_SHIFT);
    end
  end
endmodule
